// File: rtl/fp_addsub_prealign_if.sv
`default_nettype none
// ============================================================================
//  Module      : fp_addsub_prealign_if
//  Description : Operand/result bundle for the binary32 add/sub pre-align stage
//  Revision    : 1.0 - initial release
// ============================================================================
interface fp_addsub_prealign_if;
    logic        in_valid;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        opcode;
    logic        out_valid;
    logic [1:0]  n_concat;
    logic [7:0]  exp_r;
    logic [7:0]  shift;
    logic        swap;
    logic [23:0] sig_big;
    logic [23:0] sig_small;
    logic        complement;
    logic        sign_r;

    modport master (
        output in_valid, op_a, op_b, opcode,
        input  out_valid, n_concat, exp_r, shift, swap,
               sig_big, sig_small, complement, sign_r
    );

    modport slave (
        input  in_valid, op_a, op_b, opcode,
        output out_valid, n_concat, exp_r, shift, swap,
               sig_big, sig_small, complement, sign_r
    );
endinterface
`default_nettype wire

// File: rtl/fp_addsub_prealign.sv
`default_nettype none
// ============================================================================
//  Module      : fp_addsub_prealign
//  Description : Registered exponent compare, operand swap and sign decision
//                for the binary32 add/sub datapath (1-cycle latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_addsub_prealign (
    input  logic                 clk,
    input  logic                 rst_n,
    fp_addsub_prealign_if.slave  bus
);

    logic [7:0]  w_exp_a;
    logic [7:0]  w_exp_b;
    logic        w_hid_a;
    logic        w_hid_b;
    logic [7:0]  w_exp_a_d;
    logic [7:0]  w_exp_b_d;
    logic        w_borrow;
    logic [7:0]  w_exp_r;
    logic [7:0]  w_shift;
    logic [23:0] w_sig_a;
    logic [23:0] w_sig_b;
    logic        w_complement;
    logic        w_sign_r;

    // Zero and denormal operands behave as exponent 1 with no hidden bit.
    assign w_exp_a   = bus.op_a[30:23];
    assign w_exp_b   = bus.op_b[30:23];
    assign w_hid_a   = |w_exp_a;
    assign w_hid_b   = |w_exp_b;
    assign w_exp_a_d = w_hid_a ? w_exp_a : 8'd1;
    assign w_exp_b_d = w_hid_b ? w_exp_b : 8'd1;
    assign w_sig_a   = {w_hid_a, bus.op_a[22:0]};
    assign w_sig_b   = {w_hid_b, bus.op_b[22:0]};

    assign w_borrow     = (w_exp_a_d < w_exp_b_d);
    assign w_exp_r      = w_borrow ? w_exp_b_d : w_exp_a_d;
    assign w_shift      = w_borrow ? (w_exp_b_d - w_exp_a_d) : (w_exp_a_d - w_exp_b_d);
    assign w_complement = bus.op_a[31] ^ bus.op_b[31] ^ bus.opcode;
    // Equal exponents keep sign_a; the adder fixes it if the difference goes negative.
    assign w_sign_r     = w_borrow ? (bus.op_b[31] ^ bus.opcode) : bus.op_a[31];

    logic        r_out_valid;
    logic [1:0]  r_n_concat;
    logic [7:0]  r_exp_r;
    logic [7:0]  r_shift;
    logic        r_swap;
    logic [23:0] r_sig_big;
    logic [23:0] r_sig_small;
    logic        r_complement;
    logic        r_sign_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_n_concat   <= 2'b00;
            r_exp_r      <= 8'd0;
            r_shift      <= 8'd0;
            r_swap       <= 1'b0;
            r_sig_big    <= 24'd0;
            r_sig_small  <= 24'd0;
            r_complement <= 1'b0;
            r_sign_r     <= 1'b0;
        end else begin
            r_out_valid  <= bus.in_valid;
            r_n_concat   <= {w_hid_a, w_hid_b};
            r_exp_r      <= w_exp_r;
            r_shift      <= w_shift;
            r_swap       <= w_borrow;
            r_sig_big    <= w_borrow ? w_sig_b : w_sig_a;
            r_sig_small  <= w_borrow ? w_sig_a : w_sig_b;
            r_complement <= w_complement;
            r_sign_r     <= w_sign_r;
        end
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.n_concat   = r_n_concat;
    assign bus.exp_r      = r_exp_r;
    assign bus.shift      = r_shift;
    assign bus.swap       = r_swap;
    assign bus.sig_big    = r_sig_big;
    assign bus.sig_small  = r_sig_small;
    assign bus.complement = r_complement;
    assign bus.sign_r     = r_sign_r;

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_prealign.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_addsub_prealign
//  Description : Self-checking bench for fp_addsub_prealign
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_addsub_prealign;

    typedef struct packed {
        logic        ov;
        logic [1:0]  nc;
        logic [7:0]  er;
        logic [7:0]  sh;
        logic        sw;
        logic [23:0] sb;
        logic [23:0] ss;
        logic        cp;
        logic        sr;
    } res_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fp_addsub_prealign_if bus ();

    fp_addsub_prealign dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic res_t observe();
        res_t r;
        r = '{ov: bus.out_valid, nc: bus.n_concat, er: bus.exp_r, sh: bus.shift,
              sw: bus.swap, sb: bus.sig_big, ss: bus.sig_small,
              cp: bus.complement, sr: bus.sign_r};
        return r;
    endfunction

    // Reference: integer effective exponents, larger one wins, ties go to a.
    function automatic res_t model(logic [31:0] a, logic [31:0] b, logic op);
        res_t r;
        int   ea, eb, fa, fb, ha, hb;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        ha = (ea != 0) ? 1 : 0;
        hb = (eb != 0) ? 1 : 0;
        if (ea == 0) ea = 1;
        if (eb == 0) eb = 1;
        fa = ha * 8388608 + int'(a[22:0]);
        fb = hb * 8388608 + int'(b[22:0]);
        r.ov = 1'b1;
        r.nc = 2'(ha * 2 + hb);
        r.cp = ((int'(a[31]) + int'(b[31]) + int'(op)) % 2) == 1;
        if (eb > ea) begin
            r.sw = 1'b1; r.er = 8'(eb); r.sh = 8'(eb - ea);
            r.sb = 24'(fb); r.ss = 24'(fa); r.sr = b[31] ^ op;
        end else begin
            r.sw = 1'b0; r.er = 8'(ea); r.sh = 8'(ea - eb);
            r.sb = 24'(fa); r.ss = 24'(fb); r.sr = a[31];
        end
        return r;
    endfunction

    function automatic logic [7:0] rnd_exp(logic [7:0] other);
        logic [7:0] e;
        case ($urandom_range(0, 5))
            0:       e = 8'd0;
            1:       e = 8'd255;
            2:       e = other;
            3:       e = 8'd1;
            default: e = 8'($urandom);
        endcase
        return e;
    endfunction

    task automatic drive(logic v, logic [31:0] a, logic [31:0] b, logic op);
        @(negedge clk);
        bus.in_valid = v;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.opcode   = op;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        res_t got;
        rst_n = 1'b0;
        drive(1'b1, 32'h3F800000, 32'h40000000, 1'b0);
        drive(1'b1, 32'hBF800000, 32'h7F7FFFFF, 1'b1);
        got = observe();
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_state got %h expected %h", got, res_t'('0));
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] va [5] = '{32'hBF800000, 32'hBE800000, 32'h80000000, 32'h3FC00000, 32'h00000001};
        logic [31:0] vb [5] = '{32'h3D4CCCCD, 32'h3F9D70A4, 32'h3A83126F, 32'hBFA00000, 32'h00400000};
        logic        vo [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        res_t        ve [5];
        res_t        got;
        ve[0] = '{1'b1, 2'b11, 8'h7F, 8'h05, 1'b0, 24'h800000, 24'hCCCCCD, 1'b1, 1'b1};
        ve[1] = '{1'b1, 2'b11, 8'h7F, 8'h02, 1'b1, 24'h9D70A4, 24'h800000, 1'b0, 1'b1};
        ve[2] = '{1'b1, 2'b01, 8'h75, 8'h74, 1'b1, 24'h83126F, 24'h000000, 1'b0, 1'b1};
        ve[3] = '{1'b1, 2'b11, 8'h7F, 8'h00, 1'b0, 24'hC00000, 24'hA00000, 1'b1, 1'b0};
        ve[4] = '{1'b1, 2'b00, 8'h01, 8'h00, 1'b0, 24'h000001, 24'h400000, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, va[i], vb[i], vo[i]);
            got = observe();
            checks++;
            if (got !== ve[i]) begin
                errors++;
                $display("FAIL directed_%0d got %h expected %h", i, got, ve[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        logic        v, op;
        res_t        exp_r, got;
        for (int i = 0; i < 400; i++) begin
            a = $urandom;
            b = $urandom;
            a[30:23] = rnd_exp(8'($urandom));
            b[30:23] = rnd_exp(a[30:23]);
            op = 1'($urandom);
            v  = ($urandom_range(0, 7) != 0);
            drive(v, a, b, op);
            got = observe();
            checks++;
            if (v) begin
                exp_r = model(a, b, op);
                if (got !== exp_r) begin
                    errors++;
                    $display("FAIL random_%0d a=%h b=%h op=%0d got %h expected %h",
                             i, a, b, op, got, exp_r);
                end
            end else if (got.ov !== 1'b0) begin
                errors++;
                $display("FAIL idle_valid_%0d got %b expected 0", i, got.ov);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        logic        op;
        res_t        got, exp_r;
        for (int i = 0; i < 20; i++) begin
            a = $urandom;
            b = $urandom;
            op = 1'($urandom);
            drive(1'b1, a, b, op);
            got = observe();
            exp_r = model(a, b, op);
            checks++;
            if (got !== exp_r) begin
                errors++;
                $display("FAIL back_to_back_%0d got %h expected %h", i, got, exp_r);
            end
        end
    endtask

    task automatic test_reset_midstream();
        res_t got, exp_r;
        drive(1'b1, 32'h41200000, 32'h3F000000, 1'b1);
        rst_n = 1'b0;
        drive(1'b1, 32'hC1200000, 32'h3F000000, 1'b0);
        got = observe();
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_midstream got %h expected %h", got, res_t'('0));
        end
        rst_n = 1'b1;
        drive(1'b1, 32'h3F000000, 32'h41200000, 1'b1);
        got = observe();
        exp_r = model(32'h3F000000, 32'h41200000, 1'b1);
        checks++;
        if (got !== exp_r) begin
            errors++;
            $display("FAIL post_reset_latency got %h expected %h", got, exp_r);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        got = observe();
        checks++;
        if (got.ov !== 1'b0) begin
            errors++;
            $display("FAIL drop_valid got %b expected 0", got.ov);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.op_a     = 32'h0;
        bus.op_b     = 32'h0;
        bus.opcode   = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
